axi_lite_master: RTL and testbench
==================================

# axi_lite_master

- Single-outstanding AXI4-Lite initiator between the core's load/store/fetch request port and the memory bus.
- Converts one upstream request (read or write) into AR/R or AW/W/B transactions toward the SRAM/memory responder.
- Returns the read data or write completion, plus an error flag, on a valid/ready response port.
- Accepts no new request until the current response has been consumed.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; only used when the watchdog macro is defined.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge
- rst  input  1  reset, synchronous and active-low (0 = reset)
- req_valid  input  1  upstream request valid
- req_ready  output  1  request accepted when req_valid & req_ready
- req_wen  input  1  1 = write, 0 = read
- req_addr  input  32  byte address
- req_wdata  input  32  write data
- req_wstrb  input  4  byte strobe, also the access-size code for reads
- resp_valid  output  1  response valid
- resp_ready  input  1  response consumed when resp_valid & resp_ready
- resp_rdata  output  32  read data; 0 for writes
- resp_err  output  1  1 if RRESP/BRESP != 2'b00, or on watchdog timeout
- ARVALID, ARREADY, ARADDR  out/in/out  1/1/32  read address channel
- RVALID, RREADY, RDATA, RRESP  in/out/in/in  1/1/32/2  read data channel
- AWVALID, AWREADY, AWADDR  out/in/out  1/1/32  write address channel
- WVALID, WREADY, WDATA, WSTRB  out/in/out/out  1/1/32/4  write data channel
- BVALID, BREADY, BRESP  in/out/in  1/1/2  write response channel

## Operation
FSM states:
- IDLE: req_ready=1. On accept, latch addr, wdata and wstrb. Go to RD_ADDR if req_wen=0, otherwise WR.
- RD_ADDR: ARVALID=1. When ARREADY is high, go to RD_DATA.
- RD_DATA: RREADY=1. When RVALID is high, latch RDATA into resp_rdata, set resp_err=(RRESP!=0), go to RESP.
- WR: AWVALID=~aw_done and WVALID=~w_done.
  - Set aw_done on the AW handshake and w_done on the W handshake; the two may complete in the same or in different cycles.
  - Go to WR_RESP in the cycle where both are done, counting a handshake that completes in that cycle.
- WR_RESP: BREADY=1. When BVALID is high, set resp_err=(BRESP!=0), set resp_rdata=0, go to RESP.
- RESP: resp_valid=1. When resp_ready is high, clear aw_done/w_done and go to IDLE.

Protocol rules:
- ARADDR, AWADDR, WDATA and WSTRB are driven from the latched registers and stay stable while the corresponding VALID is high.
- WSTRB also carries the latched strobe during reads, because the responder uses it as the read length.
- Once a VALID is asserted it is never dropped before its handshake. The only exceptions are reset and watchdog abort.
- resp_rdata and resp_err hold their values while in RESP.

Reset:
- While rst=0, the next edge forces IDLE and clears aw_done, w_done and all latches.
- Afterwards: req_ready=1; resp_valid, ARVALID, AWVALID, WVALID, RREADY and BREADY are 0; resp_rdata, resp_err, ARADDR, AWADDR, WDATA and WSTRB are 0.
- Reset in the middle of a transaction abandons it with no response.

## Timing
- All AXI and response outputs are decoded from registered state; no combinational path from AXI inputs to AXI outputs.
- Read: accept at cycle 0, ARVALID at 1. With ARREADY=1 at 1, RREADY at 2. With RVALID=1 at 2, resp_valid at 3. Minimum latency is 3 cycles.
- Write: accept at 0, AWVALID and WVALID at 1. With both readies at 1, BREADY at 2. With BVALID at 2, resp_valid at 3.
- Every responder stall cycle (ARREADY, RVALID, AWREADY, WREADY or BVALID low) adds one cycle.
- Back-to-back: resp handshake at cycle n, IDLE at n+1, next accept no earlier than n+1.

## Configuration
- With AXI_MASTER_TIMEOUT_EN defined:
  - An 8-bit (or wider, to fit TIMEOUT_CYCLES) counter clears on accept and increments each cycle in RD_ADDR, RD_DATA, WR or WR_RESP.
  - When it reaches TIMEOUT_CYCLES, the master drops all AXI valid/ready outputs and enters RESP with resp_err=1 and resp_rdata=0.
  - This abort is a debug aid; the bus is considered broken afterwards.
- Without the macro: no counter, and the master waits indefinitely.

## Test plan
- Read, zero-wait responder returning 0xDEADBEEF with RRESP=0: resp_valid at cycle 3, resp_rdata=0xDEADBEEF, resp_err=0, ARADDR equal to req_addr.
- Write of addr 0x80000010, data 0x12345678, strb 0xF, with AWREADY delayed 2 cycles and WREADY immediate: WVALID drops after cycle 1, AWVALID holds until its handshake, BREADY follows, and resp arrives 2 cycles later than the zero-wait case.
- RVALID held high while resp_ready=0 for 4 cycles: resp_valid and resp_rdata stay stable, req_ready=0, and no second AR is issued.
- BRESP=2'b10: resp_err=1. Then a read with RRESP=0: resp_err=0.
- rst=0 asserted during RD_DATA: IDLE on the next edge, all valid/ready outputs 0, no resp_valid. A new request after rst=1 completes normally.
- AXI_MASTER_TIMEOUT_EN with TIMEOUT_CYCLES=16 and a responder that never asserts ARREADY: ARVALID drops, and resp_valid=1 with resp_err=1 exactly 16 cycles after ARVALID first asserts.

Source files
------------

// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_master
//  Purpose  : Single-outstanding AXI4-Lite initiator. Turns one upstream
//             load/store/fetch request into an AR/R or AW/W/B exchange and
//             returns read data or write completion plus an error flag on a
//             valid/ready response port.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst (sync, active-low)
//    req_*  : upstream request (valid/ready, wen, addr, wdata, wstrb)
//    resp_* : upstream response (valid/ready, rdata, err)
//    AR*/R* : AXI4-Lite read address / read data channels
//    AW*/W*/B* : AXI4-Lite write address / data / response channels
//  Options
//    AXI_MASTER_TIMEOUT_EN : enables a watchdog that aborts a stuck
//                            transaction after TIMEOUT_CYCLES cycles and
//                            reports it as an error response.
// ============================================================================
module axi_lite_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    // upstream request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    // upstream response
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    // AXI read address / data
    output logic        ARVALID,
    input  logic        ARREADY,
    output logic [31:0] ARADDR,
    input  logic        RVALID,
    output logic        RREADY,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    // AXI write address / data / response
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] AWADDR,
    output logic        WVALID,
    input  logic        WREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    input  logic        BVALID,
    output logic        BREADY,
    input  logic [1:0]  BRESP
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR      = 3'd3,
        S_WR_RESP = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        w_accept;
    logic        w_busy;
    logic        w_timeout;

    // All handshake outputs are pure decodes of registered state.
    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign ARVALID    = (r_state == S_RD_ADDR);
    assign RREADY     = (r_state == S_RD_DATA);
    assign AWVALID    = (r_state == S_WR) && !r_aw_done;
    assign WVALID     = (r_state == S_WR) && !r_w_done;
    assign BREADY     = (r_state == S_WR_RESP);

    assign ARADDR     = r_addr;
    assign AWADDR     = r_addr;
    assign WDATA      = r_wdata;
    // Driven during reads as well: the responder uses it as the read length.
    assign WSTRB      = r_wstrb;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_busy   = (r_state == S_RD_ADDR) || (r_state == S_RD_DATA) ||
                      (r_state == S_WR)      || (r_state == S_WR_RESP);

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] r_cnt;

    // Fires in the cycle whose increment would make the count reach the
    // limit, so RESP is entered exactly TIMEOUT_CYCLES cycles after the
    // first busy cycle.
    assign w_timeout = w_busy && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout_param;
    assign w_unused_timeout_param = (TIMEOUT_CYCLES == 0);
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (req_valid) w_state_next = req_wen ? S_WR : S_RD_ADDR;
            S_RD_ADDR: if (ARREADY)   w_state_next = S_RD_DATA;
            S_RD_DATA: if (RVALID)    w_state_next = S_RESP;
            // A handshake completing this cycle counts towards "both done".
            S_WR:      if ((r_aw_done || AWREADY) && (r_w_done || WREADY))
                           w_state_next = S_WR_RESP;
            S_WR_RESP: if (BVALID)    w_state_next = S_RESP;
            S_RESP:    if (resp_ready) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_next = S_RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
            end
            if (AWVALID && AWREADY) r_aw_done <= 1'b1;
            if (WVALID && WREADY)   r_w_done  <= 1'b1;
            if ((r_state == S_RD_DATA) && RVALID) begin
                r_rdata <= RDATA;
                r_err   <= (RRESP != 2'b00);
            end
            if ((r_state == S_WR_RESP) && BVALID) begin
                r_rdata <= '0;
                r_err   <= (BRESP != 2'b00);
            end
            if ((r_state == S_RESP) && resp_ready) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            // Abort wins over any handshake landing in the same cycle.
            if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_master
//  Purpose  : Directed self-checking bench for axi_lite_master. The AXI
//             responder is driven by hand, cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_wen = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_ready = 1'b0;
    logic        ARREADY = 1'b0, RVALID = 1'b0, AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
    logic [31:0] RDATA = '0;
    logic [1:0]  RRESP = '0, BRESP = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, ARADDR, AWADDR, WDATA;
    logic [3:0]  WSTRB;
    logic        ARVALID, RREADY, AWVALID, WVALID, BREADY;

    int n_cmp = 0;
    int n_err = 0;

    axi_lite_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Concatenated valid/ready outputs: {req_ready,resp_valid,ARVALID,RREADY,AWVALID,WVALID,BREADY}
    function automatic logic [31:0] hs();
        return {25'd0, req_ready, resp_valid, ARVALID, RREADY, AWVALID, WVALID, BREADY};
    endfunction

    task automatic request(input logic wen, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = d; req_wstrb = s;
    endtask

    task automatic axi_idle();
        ARREADY = 0; RVALID = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
        RRESP = 0; BRESP = 0; RDATA = 0;
    endtask

    // Consume the response currently presented; then master must be idle.
    task automatic consume(input string tag);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, "_after_consume"}, hs(), 32'h40);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b0;
        step(); step();
        check("rst_hs", hs(), 32'h40);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", {31'd0, resp_err}, 32'h0);
        check("rst_araddr", ARADDR, 32'h0);
        check("rst_wdata", WDATA, 32'h0);
        check("rst_wstrb", {28'd0, WSTRB}, 32'h0);
        rst = 1'b1;
        step();

        // ---------------- zero-wait read ----------------
        request(1'b0, 32'h1000_0004, 32'h0, 4'hF);
        ARREADY = 1; RVALID = 1; RDATA = 32'hDEAD_BEEF; RRESP = 2'b00;
        step();                                  // cycle 1
        req_valid = 1'b0;
        check("rd_c1_hs", hs(), 32'h10);
        check("rd_araddr", ARADDR, 32'h1000_0004);
        check("rd_wstrb", {28'd0, WSTRB}, 32'hF);
        step();                                  // cycle 2
        check("rd_c2_hs", hs(), 32'h08);
        step();                                  // cycle 3
        check("rd_c3_hs", hs(), 32'h20);
        check("rd_rdata", resp_rdata, 32'hDEAD_BEEF);
        check("rd_err", {31'd0, resp_err}, 32'h0);
        axi_idle();
        consume("rd");

        // ---------------- write, AWREADY 2 cycles late ----------------
        request(1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF);
        AWREADY = 0; WREADY = 1; BVALID = 1; BRESP = 2'b00;
        step();                                  // cycle 1
        req_valid = 1'b0;
        check("wr_c1_hs", hs(), 32'h06);
        check("wr_awaddr", AWADDR, 32'h8000_0010);
        check("wr_wdata", WDATA, 32'h1234_5678);
        step();                                  // cycle 2
        check("wr_c2_hs", hs(), 32'h04);
        step();                                  // cycle 3
        check("wr_c3_hs", hs(), 32'h04);
        check("wr_c3_awaddr", AWADDR, 32'h8000_0010);
        AWREADY = 1;
        step();                                  // cycle 4
        check("wr_c4_hs", hs(), 32'h01);
        step();                                  // cycle 5
        check("wr_c5_hs", hs(), 32'h20);
        check("wr_rdata", resp_rdata, 32'h0);
        check("wr_err", {31'd0, resp_err}, 32'h0);
        axi_idle();
        consume("wr");

        // ---------------- response back-pressure ----------------
        request(1'b0, 32'h0000_0040, 32'h0, 4'h3);
        ARREADY = 1; RVALID = 1; RDATA = 32'hA5A5_0F0F;
        step(); step(); step();                  // cycle 3: in RESP
        // keep a new request pending and RVALID high while stalled
        request(1'b0, 32'h0000_0080, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            check("bp_hs", hs(), 32'h20);
            check("bp_rdata", resp_rdata, 32'hA5A5_0F0F);
            check("bp_araddr", ARADDR, 32'h0000_0040);
            step();
        end
        req_valid = 1'b0;
        axi_idle();
        consume("bp");

        // ---------------- BRESP error, then clean read ----------------
        request(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'h1);
        AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b10;
        step();
        req_valid = 1'b0;
        step(); step();                          // cycle 3
        check("berr_hs", hs(), 32'h20);
        check("berr_err", {31'd0, resp_err}, 32'h1);
        check("berr_rdata", resp_rdata, 32'h0);
        axi_idle();
        consume("berr");
        request(1'b0, 32'h0000_0104, 32'h0, 4'hF);
        ARREADY = 1; RVALID = 1; RDATA = 32'h0BAD_F00D; RRESP = 2'b00;
        step();
        req_valid = 1'b0;
        step(); step();
        check("rok_hs", hs(), 32'h20);
        check("rok_err", {31'd0, resp_err}, 32'h0);
        check("rok_rdata", resp_rdata, 32'h0BAD_F00D);
        axi_idle();
        consume("rok");

        // ---------------- reset during RD_DATA ----------------
        request(1'b0, 32'h0000_0200, 32'h0, 4'hF);
        ARREADY = 1; RVALID = 0;
        step();
        req_valid = 1'b0;
        step();                                  // cycle 2: RD_DATA
        check("mrst_c2_hs", hs(), 32'h08);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mrst_hs", hs(), 32'h40);
        check("mrst_araddr", ARADDR, 32'h0);
        axi_idle();
        step();
        check("mrst_idle_hs", hs(), 32'h40);
        request(1'b1, 32'h0000_0300, 32'h5555_AAAA, 4'hC);
        AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b00;
        step();
        req_valid = 1'b0;
        check("mrst_wr_wstrb", {28'd0, WSTRB}, 32'hC);
        step(); step();
        check("mrst_wr_hs", hs(), 32'h20);
        check("mrst_wr_err", {31'd0, resp_err}, 32'h0);
        axi_idle();
        consume("mrst_wr");

`ifdef AXI_MASTER_TIMEOUT_EN
        // ---------------- watchdog on a dead ARREADY ----------------
        begin
            int waited;
            waited = 0;
            request(1'b0, 32'h0000_0400, 32'h0, 4'hF);
            step();                              // cycle 1: ARVALID rises
            req_valid = 1'b0;
            check("to_arvalid", {31'd0, ARVALID}, 32'h1);
            while (!resp_valid && waited < 40) begin
                step();
                waited++;
            end
            check("to_latency", waited, 32'd16);
            check("to_hs", hs(), 32'h20);
            check("to_err", {31'd0, resp_err}, 32'h1);
            check("to_rdata", resp_rdata, 32'h0);
            consume("to");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
